// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside the ID stage. It tracks in-flight writers
// per stage and produces forwarding selects, load-use stall/bubble, and IF/ID flush.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES       = 3,
    parameter int REG_AW           = 5,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 16,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_pause,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs,
    input  logic [REG_AW-1:0]     id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_we,
    input  logic [REG_AW-1:0]     id_wa,
    input  logic                  id_is_load,
    input  logic                  branch_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Scoreboard: index gi holds the entry for stage gi+1
    logic [NUM_STAGES-1:0] valid_reg, we_reg, load_reg;
    logic [REG_AW-1:0]     wa_reg [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_next, we_next, load_next;
    logic [REG_AW-1:0]     wa_next [NUM_STAGES];
    logic [CNT_W-1:0]      stall_cnt_reg;

    logic [NUM_STAGES-1:0] rs_hit, rt_hit;
    logic [SEL_W-1:0]      rs_sel_raw, rt_sel_raw;
    logic                  rs_early, rt_early;
    logic                  rs_chk, rt_chk;
    logic                  rs_haz, rt_haz;
    logic                  luse;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
            assign rs_hit[gi] = valid_reg[gi] & we_reg[gi] & (wa_reg[gi] == id_rs);
            assign rt_hit[gi] = valid_reg[gi] & we_reg[gi] & (wa_reg[gi] == id_rt);
        end
    endgenerate

    // Returns {load_not_ready, stage}; scanning oldest to youngest lets the youngest win.
    function automatic logic [SEL_W:0] find_writer(input logic [NUM_STAGES-1:0] hit,
                                                   input logic [NUM_STAGES-1:0] ld);
        logic [SEL_W-1:0] sel;
        logic             early;
        sel   = '0;
        early = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel   = SEL_W'(k + 1);
                early = ld[k] && ((k + 1) < LOAD_READY_STAGE);
            end
        end
        return {early, sel};
    endfunction

    always_comb begin
        {rs_early, rs_sel_raw} = find_writer(rs_hit, load_reg);
        {rt_early, rt_sel_raw} = find_writer(rt_hit, load_reg);
    end

    assign rs_chk = id_valid & id_rs_used & (|id_rs);
    assign rt_chk = id_valid & id_rt_used & (|id_rt);
    assign rs_haz = rs_chk & rs_early;
    assign rt_haz = rt_chk & rt_early;
    assign luse   = (rs_haz | rt_haz) & ~ext_pause;

    assign stall_if    = luse | ext_pause;
    assign stall_id    = luse | ext_pause;
    assign bubble_ex   = luse;
    assign flush_id    = branch_taken & ~luse & ~ext_pause;
    assign fwd_rs_sel  = rs_chk ? rs_sel_raw : '0;
    assign fwd_rt_sel  = rt_chk ? rt_sel_raw : '0;
    assign stage_valid = valid_reg;
    assign stall_cnt   = stall_cnt_reg;

    // Stage 1 takes the ID instruction, or a bubble while the load-use stall holds ID
    always_comb begin
        valid_next = valid_reg;
        we_next    = we_reg;
        load_next  = load_reg;
        for (int k = 0; k < NUM_STAGES; k++) begin
            wa_next[k] = wa_reg[k];
        end
        if (!ext_pause) begin
            valid_next[0] = id_valid & ~luse;
            we_next[0]    = id_valid & id_we & (|id_wa) & ~luse;
            load_next[0]  = id_valid & id_is_load & ~luse;
            wa_next[0]    = luse ? '0 : id_wa;
            for (int k = 1; k < NUM_STAGES; k++) begin
                valid_next[k] = valid_reg[k-1];
                we_next[k]    = we_reg[k-1];
                load_next[k]  = load_reg[k-1];
                wa_next[k]    = wa_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            we_reg    <= '0;
            load_reg  <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                wa_reg[k] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            we_reg    <= we_next;
            load_reg  <= load_next;
            for (int k = 0; k < NUM_STAGES; k++) begin
                wa_reg[k] <= wa_next[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (luse && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule
